// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Fetch sequencer for the read-only instruction memory. Owns the fetch PC,
//   drives the memory address, waits out the fixed read latency and offers
//   each fetched word together with its PC to decode over valid/ready.
//   Branch redirects squash any read in flight; a misaligned redirect target
//   raises a sticky error and parks the controller in HALT.
//
// Parameters
//   LAT       instruction-memory read latency in cycles (>= 1)
//   RESET_PC  fetch PC loaded on reset
//
// Ports
//   CLK             in   1   clock, rising edge
//   Reset_L         in   1   asynchronous reset, active low
//   imem_addr       out  64  address to instruction memory (always equals the fetch PC)
//   imem_data       in   32  instruction word from memory
//   inst_valid      out  1   inst/inst_pc hold a valid fetched instruction
//   inst_ready      in   1   decode accepts the instruction this cycle
//   inst            out  32  fetched instruction word
//   inst_pc         out  64  address of inst
//   redirect_valid  in   1   load redirect_pc as the new fetch PC
//   redirect_pc     in   64  redirect target
//   halt_req        in   1   level: stop issuing new fetches
//   halted          out  1   controller is in HALT
//   misalign_err    out  1   sticky: a redirect target had bits [1:0] != 0
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int unsigned LAT      = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset_L,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        misalign_err
);

    localparam int unsigned      CNT_W    = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,  // read in flight
        S_HOLD = 2'd1,  // instruction offered to decode
        S_HALT = 2'd2   // no fetching
    } state_e;

    state_e             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        inst_q;
    logic [63:0]        inst_pc_q;
    logic               err_q, err_d;
    logic               inst_valid_q, inst_valid_d;
    logic               halted_q, halted_d;
    logic               capture;

    // State register
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        capture = 1'b0;

        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // Last cycle of the read: the word on imem_data belongs to pc_q.
                if (cnt_q == CNT_ONE) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    pc_d    = pc_q + 64'd4;
                    cnt_d   = CNT_INIT;
                    state_d = halt_req ? S_HALT : S_WAIT;
                end
            end
            S_HALT: begin
            end
            default: begin
                state_d = S_WAIT;
                cnt_d   = CNT_INIT;
            end
        endcase

        // A redirect overrides everything above, including a handshake in the
        // same cycle (the offered instruction still counts as consumed).
        if (redirect_valid) begin
            capture = 1'b0;
            cnt_d   = CNT_INIT;
            if (redirect_pc[1:0] == 2'b00) begin
                pc_d    = redirect_pc;
                state_d = (state_q == S_HALT && halt_req) ? S_HALT : S_WAIT;
            end else begin
                pc_d    = pc_q;
                err_d   = 1'b1;
                state_d = S_HALT;
            end
        end
    end

    // Registered output decode from the next state
    always_comb begin
        inst_valid_d = (state_d == S_HOLD);
        halted_d     = (state_d == S_HALT);
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc_q         <= RESET_PC;
            cnt_q        <= CNT_INIT;
            inst_q       <= 32'h0;
            inst_pc_q    <= 64'h0;
            err_q        <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
            if (capture) begin
                inst_q    <= imem_data;
                inst_pc_q <= pc_q;
            end
        end
    end

    assign imem_addr    = pc_q;
    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign halted       = halted_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Directed scenarios plus a randomized run against a transaction-level model
//   of the fetch controller. The instruction memory is a one-stage registered
//   lookup, so a word is available LAT-1 cycles after its address (LAT = 2).
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    localparam int unsigned LAT      = 2;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b1;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        misalign_err;

    int n_checks = 0;
    int n_pass   = 0;

    imem_fetch_ctrl #(.LAT(LAT), .RESET_PC(RESET_PC)) dut (
        .CLK            (CLK),
        .Reset_L        (Reset_L),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .misalign_err   (misalign_err)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents: a few fixed words, hashed elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] h;
        case (a)
            64'h00: h = 32'hF840_03E9;
            64'h04: h = 32'hF840_83EA;
            64'h14: h = 32'hAA0B_014A;
            64'h1C: h = 32'hB400_008C;
            default: h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
        endcase
        return h;
    endfunction

    logic [31:0] mem_q;
    always_ff @(posedge CLK) mem_q <= mem_word(imem_addr);
    assign imem_data = mem_q;

    // ---------------- reference model ----------------
    logic [63:0] m_pc;
    int          m_wait;     // cycles left on the current read, 0 = no read
    bit          m_offer;    // an instruction is on offer to decode
    bit          m_stop;     // fetching stopped
    logic [31:0] m_inst;
    logic [63:0] m_inst_pc;
    bit          m_err;

    task automatic model_reset();
        m_pc = RESET_PC; m_wait = LAT; m_offer = 0; m_stop = 0;
        m_inst = 32'h0; m_inst_pc = 64'h0; m_err = 0;
    endtask

    task automatic model_step();
        if (redirect_valid) begin
            m_offer = 0;
            if (redirect_pc[1:0] == 2'b00) begin
                m_pc = redirect_pc;
                if (m_stop && halt_req) m_wait = 0;
                else begin m_stop = 0; m_wait = LAT; end
            end else begin
                m_err = 1; m_stop = 1; m_wait = 0;
            end
        end else if (!m_stop) begin
            if (m_offer) begin
                if (inst_ready) begin
                    m_pc = m_pc + 64'd4;
                    m_offer = 0;
                    if (halt_req) m_stop = 1;
                    else m_wait = LAT;
                end
            end else if (m_wait == 1) begin
                m_inst = mem_word(m_pc); m_inst_pc = m_pc;
                m_offer = 1; m_wait = 0;
            end else begin
                m_wait = m_wait - 1;
            end
        end
    endtask

    function automatic logic [162:0] mdl_vec();
        return {m_pc, m_offer, m_inst, m_inst_pc, m_stop, m_err};
    endfunction

    logic [162:0] dut_vec;
    assign dut_vec = {imem_addr, inst_valid, inst, inst_pc, halted, misalign_err};

    // One clock: model advances on the same edge the DUT samples; returns #1 later.
    task automatic tick();
        @(posedge CLK);
        if (Reset_L) model_step();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        Reset_L = 1'b0;
        model_reset();
        #1;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'h0) $display("FAIL reset_inst got=%h want=0", inst); else n_pass++;
        n_checks++; if (inst_pc !== 64'h0) $display("FAIL reset_inst_pc got=%h want=0", inst_pc); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b want=0", halted); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL reset_err got=%b want=0", misalign_err); else n_pass++;
        tick();
        Reset_L = 1'b1;
    endtask

    task automatic test_basic_fetch();
        bit got;
        inst_ready = 1'b1;
        tick();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL basic_valid_c1 got=%b want=0", inst_valid); else n_pass++;
        tick();
        n_checks++; if (inst_valid !== 1'b1) $display("FAIL basic_valid_c2 got=%b want=1", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'hF840_03E9) $display("FAIL basic_inst0 got=%h want=F84003E9", inst); else n_pass++;
        n_checks++; if (inst_pc !== 64'h0) $display("FAIL basic_pc0 got=%h want=0", inst_pc); else n_pass++;
        tick();
        n_checks++; if (imem_addr !== 64'h4) $display("FAIL basic_addr_adv got=%h want=4", imem_addr); else n_pass++;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec()) $display("FAIL basic_model dut=%h model=%h", dut_vec, mdl_vec()); else n_pass++;
            got = inst_valid;
        end
        n_checks++; if (got !== 1'b1) $display("FAIL basic_timeout got=%b want=1", got); else n_pass++;
        n_checks++; if (inst !== 32'hF840_83EA) $display("FAIL basic_inst1 got=%h want=F84083EA", inst); else n_pass++;
        n_checks++; if (inst_pc !== 64'h4) $display("FAIL basic_pc1 got=%h want=4", inst_pc); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit got;
        inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h14;
        tick();
        redirect_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec()) $display("FAIL bp_model dut=%h model=%h", dut_vec, mdl_vec()); else n_pass++;
            got = inst_valid;
        end
        n_checks++; if (got !== 1'b1) $display("FAIL bp_timeout got=%b want=1", got); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({inst_valid, inst, inst_pc, imem_addr} !== {1'b1, 32'hAA0B_014A, 64'h14, 64'h14})
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%h/%h want=1/AA0B014A/14/14", i, inst_valid, inst, inst_pc, imem_addr);
            else n_pass++;
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_checks++; if ({inst_valid, imem_addr} !== {1'b0, 64'h18}) $display("FAIL bp_release got=%b/%h want=0/18", inst_valid, imem_addr); else n_pass++;
    endtask

    task automatic test_redirect();
        bit got;
        bit seen20;
        redirect_valid = 1'b1; redirect_pc = 64'h20;
        tick();
        redirect_pc = 64'h1C;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (imem_addr !== 64'h1C) $display("FAIL redir_addr got=%h want=1C", imem_addr); else n_pass++;
        got = 0; seen20 = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec()) $display("FAIL redir_model dut=%h model=%h", dut_vec, mdl_vec()); else n_pass++;
            if (inst_valid && inst_pc == 64'h20) seen20 = 1;
            got = inst_valid;
        end
        n_checks++; if (got !== 1'b1) $display("FAIL redir_timeout got=%b want=1", got); else n_pass++;
        n_checks++; if (seen20 !== 1'b0) $display("FAIL redir_squash got=%b want=0", seen20); else n_pass++;
        n_checks++; if ({inst_pc, inst} !== {64'h1C, 32'hB400_008C}) $display("FAIL redir_inst got=%h/%h want=1C/B400008C", inst_pc, inst); else n_pass++;
        // redirect coincident with handshake
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h40;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if ({inst_valid, imem_addr} !== {1'b0, 64'h40}) $display("FAIL redir_hs got=%b/%h want=0/40", inst_valid, imem_addr); else n_pass++;
        inst_ready = 1'b0;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            got = inst_valid;
        end
        n_checks++; if ({got, inst_pc} !== {1'b1, 64'h40}) $display("FAIL redir_hs_next got=%b/%h want=1/40", got, inst_pc); else n_pass++;
    endtask

    task automatic test_misalign();
        bit got;
        redirect_valid = 1'b1; redirect_pc = 64'h22;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({misalign_err, halted, inst_valid, imem_addr} !== {1'b1, 1'b1, 1'b0, 64'h40})
            $display("FAIL mis_enter got=%b%b%b/%h want=110/40", misalign_err, halted, inst_valid, imem_addr);
        else n_pass++;
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec()) $display("FAIL mis_model dut=%h model=%h", dut_vec, mdl_vec()); else n_pass++;
        end
        inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h34; halt_req = 1'b0;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({misalign_err, halted, imem_addr} !== {1'b1, 1'b0, 64'h34})
            $display("FAIL mis_resume got=%b%b/%h want=10/34", misalign_err, halted, imem_addr);
        else n_pass++;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            got = inst_valid;
        end
        n_checks++; if ({got, inst_pc, misalign_err} !== {1'b1, 64'h34, 1'b1}) $display("FAIL mis_fetch got=%b/%h/%b want=1/34/1", got, inst_pc, misalign_err); else n_pass++;
    endtask

    task automatic test_wrap_halt();
        bit got;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            got = inst_valid;
        end
        n_checks++; if ({got, inst_pc} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) $display("FAIL wrap_fetch got=%b/%h want=1/FFFFFFFFFFFFFFFC", got, inst_pc); else n_pass++;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_checks++; if (imem_addr !== 64'h0) $display("FAIL wrap_addr got=%h want=0", imem_addr); else n_pass++;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            got = inst_valid;
        end
        halt_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({inst_valid, halted, inst_pc} !== {1'b1, 1'b0, 64'h0}) $display("FAIL halt_offer got=%b%b/%h want=10/0", inst_valid, halted, inst_pc); else n_pass++;
        end
        inst_ready = 1'b1;
        tick();
        n_checks++; if ({inst_valid, halted, imem_addr} !== {1'b0, 1'b1, 64'h4}) $display("FAIL halt_enter got=%b%b/%h want=01/4", inst_valid, halted, imem_addr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec()) $display("FAIL halt_model dut=%h model=%h", dut_vec, mdl_vec()); else n_pass++;
        end
        redirect_valid = 1'b1; redirect_pc = 64'h80;
        tick();
        n_checks++; if ({halted, imem_addr} !== {1'b1, 64'h80}) $display("FAIL halt_redir got=%b/%h want=1/80", halted, imem_addr); else n_pass++;
        halt_req = 1'b0; redirect_pc = 64'h84;
        tick();
        redirect_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            got = inst_valid;
        end
        n_checks++; if ({got, halted, inst_pc} !== {1'b1, 1'b0, 64'h84}) $display("FAIL halt_exit got=%b%b/%h want=10/84", got, halted, inst_pc); else n_pass++;
        inst_ready = 1'b0;
    endtask

    task automatic test_reset_midwait();
        bit got;
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        tick();
        redirect_valid = 1'b0;
        #2;
        Reset_L = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({imem_addr, inst_valid, inst, inst_pc, halted, misalign_err} !== {RESET_PC, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0})
            $display("FAIL midreset_outputs got=%h/%b/%h/%h/%b%b want=%h/0/0/0/00", imem_addr, inst_valid, inst, inst_pc, halted, misalign_err, RESET_PC);
        else n_pass++;
        tick();
        Reset_L = 1'b1;
        inst_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec()) $display("FAIL midreset_model dut=%h model=%h", dut_vec, mdl_vec()); else n_pass++;
            got = inst_valid;
        end
        n_checks++; if ({got, inst_pc, inst} !== {1'b1, RESET_PC, 32'hF840_03E9}) $display("FAIL midreset_fetch got=%b/%h/%h want=1/%h/F84003E9", got, inst_pc, inst, RESET_PC); else n_pass++;
        inst_ready = 1'b0;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        #2;
        Reset_L = 1'b0;
        model_reset();
        tick();
        Reset_L = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            inst_ready = ($urandom_range(0, 99) < 65);
            if ($urandom_range(0, 99) < 8) halt_req = ~halt_req;
            redirect_valid = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 90) redirect_pc = 64'($urandom_range(0, 255)) << 2;
            else redirect_pc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 99) < 3) redirect_pc = redirect_pc | 64'($urandom_range(1, 3));
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec()) begin
                errs++;
                if (errs <= 10) $display("FAIL random_model cyc=%0d dut=%h model=%h", i, dut_vec, mdl_vec());
            end else n_pass++;
        end
        redirect_valid = 1'b0; halt_req = 1'b0; inst_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_wrap_halt();
        test_reset_midwait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
